// File: rtl/inv_chk_pkg.sv
// inv_chk_pkg: shared state encoding and limits for the inverter response checker
package inv_chk_pkg;
  typedef enum logic [1:0] {IDLE, FILL, CHECK, DONE} chk_state_t;
  localparam int LATENCY_MAX = 7;
endpackage

// File: rtl/inv_exp_delay.sv
// inv_exp_delay: expected-value delay line, DEPTH cycles, pass-through at depth 0
module inv_exp_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic d,
  output logic q
);
  if (DEPTH == 0) begin : g_thru
    assign q = d;
  end else begin : g_line
    logic [DEPTH-1:0] sr_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sr_q <= '0;
      else sr_q <= flush ? '0 : DEPTH'({sr_q, d});
    assign q = sr_q[DEPTH-1];
  end
endmodule

// File: rtl/inv_resp_checker.sv
// inv_resp_checker: compares inverter response to delayed ~stim, counts samples/errors, gives verdict
module inv_resp_checker
  import inv_chk_pkg::*;
#(
  parameter int LATENCY   = 0,
  parameter int N_SAMPLES = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stim,
  input  logic             resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] smp_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             first_err_vld,
  output logic [CNT_W-1:0] first_err_idx
);
  localparam int FW = $clog2(LATENCY_MAX + 1);
  chk_state_t state_q, state_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] smp_q, smp_d, err_q, err_d, idx_q, idx_d;
  logic vld_q, vld_d, done_q, done_d, pass_q, pass_d;
  logic accept, exp_val;
  assign accept = start && (state_q == IDLE || state_q == DONE);
  // Zero latency compares against the live complement; no line to flush.
  if (LATENCY == 0) begin : g_comb
    assign exp_val = ~stim;
  end else begin : g_dly
    inv_exp_delay #(.DEPTH(LATENCY)) u_dly (
      .clk(clk), .rst_n(rst_n), .flush(accept), .d(~stim), .q(exp_val)
    );
  end
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    smp_d   = smp_q;
    err_d   = err_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
    if (accept) begin
      state_d = LATENCY == 0 ? CHECK : FILL;
      fill_d  = '0;
      smp_d   = '0;
      err_d   = '0;
      idx_d   = '0;
      vld_d   = 1'b0;
    end else if (state_q == FILL) begin
      fill_d  = fill_q + 1'b1;
      state_d = fill_q == FW'(LATENCY - 1) ? CHECK : FILL;
    end else if (state_q == CHECK) begin
      smp_d = smp_q + 1'b1;
      if (resp != exp_val) begin
        err_d = &err_q ? err_q : err_q + 1'b1;
        idx_d = vld_q ? idx_q : smp_q;
        vld_d = 1'b1;
      end
      if (smp_q == CNT_W'(N_SAMPLES - 1)) begin
        state_d = DONE;
        done_d  = 1'b1;
      end
    end
    pass_d = state_d == DONE && err_d == '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      fill_q  <= '0;
      smp_q   <= '0;
      err_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      smp_q   <= smp_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  assign busy          = state_q == FILL || state_q == CHECK;
  assign done          = done_q;
  assign pass          = pass_q;
  assign smp_cnt       = smp_q;
  assign err_cnt       = err_q;
  assign first_err_vld = vld_q;
  assign first_err_idx = idx_q;
endmodule

// File: tb/tb_inv_resp_checker.sv
// tb_inv_resp_checker: vector table + scoreboard bench over four checker configurations
module tb_inv_resp_checker;
  typedef struct {
    logic [7:0] pat;
    logic [7:0] inj;
    logic       smode;
    int         exp_err;
    int         exp_idx;
    logic       exp_vld;
    logic       exp_pass;
    logic       chk1;
    int         exp_s;
  } vec_t;
  logic clk = 0, rst_n = 0, start = 0, stim = 0, resp0 = 1, resp_s = 0, f1 = 0, f2 = 0;
  logic busy0, done0, pass0, vld0, busy2, done2, pass2, vld2, busy1, done1, pass1, vld1;
  logic busys, dones, passs, vlds;
  logic [15:0] smp0, err0, idx0, smp2, err2, idx2, smp1, err1, idx1;
  logic [1:0] smps, errs, idxs;
  int checks = 0, errors = 0;
  vec_t vecs[6];
  vec_t sb[$];
  always #5 clk = ~clk;
  // Inverter with two cycles of latency.
  always @(posedge clk) begin
    f1 <= ~stim;
    f2 <= f1;
  end
  inv_resp_checker #(.LATENCY(0), .N_SAMPLES(8), .CNT_W(16)) d0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stim(stim), .resp(resp0),
    .busy(busy0), .done(done0), .pass(pass0), .smp_cnt(smp0), .err_cnt(err0),
    .first_err_vld(vld0), .first_err_idx(idx0));
  inv_resp_checker #(.LATENCY(2), .N_SAMPLES(8), .CNT_W(16)) d2 (
    .clk(clk), .rst_n(rst_n), .start(start), .stim(stim), .resp(f2),
    .busy(busy2), .done(done2), .pass(pass2), .smp_cnt(smp2), .err_cnt(err2),
    .first_err_vld(vld2), .first_err_idx(idx2));
  inv_resp_checker #(.LATENCY(1), .N_SAMPLES(8), .CNT_W(16)) d1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stim(stim), .resp(f2),
    .busy(busy1), .done(done1), .pass(pass1), .smp_cnt(smp1), .err_cnt(err1),
    .first_err_vld(vld1), .first_err_idx(idx1));
  inv_resp_checker #(.LATENCY(0), .N_SAMPLES(3), .CNT_W(2)) ds (
    .clk(clk), .rst_n(rst_n), .start(start), .stim(stim), .resp(resp_s),
    .busy(busys), .done(dones), .pass(passs), .smp_cnt(smps), .err_cnt(errs),
    .first_err_vld(vlds), .first_err_idx(idxs));
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input vec_t v, input int k);
    int i;
    i = (k - 1) % 8;
    stim   = v.pat[i];
    resp0  = (k <= 8 && v.inj[i]) ? v.pat[i] : ~v.pat[i];
    resp_s = v.smode ? v.pat[i] : 1'b0;
  endtask
  task automatic run(input vec_t v, input int mid);
    int c0, c1, c2, cs;
    vec_t e;
    c0 = 0; c1 = 0; c2 = 0; cs = 0;
    @(negedge clk);
    start = 1;
    sb.push_back(v);
    for (int k = 1; k <= 40 && (c0 == 0 || c1 == 0 || c2 == 0 || cs == 0); k++) begin
      @(negedge clk);
      start = (k == mid);
      if (done0 && c0 == 0) begin
        c0 = k;
        chk("d0_done_cycle", k, 9);
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underflow: done with no expected entry");
        end else begin
          e = sb.pop_front();
          chk("d0_smp", int'(smp0), 8);
          chk("d0_err", int'(err0), e.exp_err);
          chk("d0_vld", int'(vld0), int'(e.exp_vld));
          chk("d0_idx", int'(idx0), e.exp_idx);
          chk("d0_pass", int'(pass0), int'(e.exp_pass));
          chk("d0_busy", int'(busy0), 0);
        end
      end
      if (done2 && c2 == 0) begin
        c2 = k;
        chk("d2_done_cycle", k, 11);
        chk("d2_pass", int'(pass2), 1);
        chk("d2_smp", int'(smp2), 8);
      end
      if (done1 && c1 == 0) begin
        c1 = k;
        chk("d1_done_cycle", k, 10);
        if (v.chk1) chk("d1_err_nonzero", int'(err1 != 0), 1);
      end
      if (dones && cs == 0) begin
        cs = k;
        chk("ds_done_cycle", k, 4);
        chk("ds_err", int'(errs), v.exp_s);
        chk("ds_smp", int'(smps), 3);
      end
      drive(v, k);
    end
    if (c0 == 0 || c1 == 0 || c2 == 0 || cs == 0) begin
      checks++; errors++;
      $display("FAIL run_timeout: done cycles d0=%0d d1=%0d d2=%0d ds=%0d", c0, c1, c2, cs);
    end
    chk("d0_done_pulse", int'(done0), 0);
    chk("d0_pass_hold", int'(pass0), int'(v.exp_pass));
    chk("d0_err_hold", int'(err0), v.exp_err);
    start = 0;
    repeat (4) @(negedge clk);
  endtask
  initial begin
    int k1, k2;
    vecs[0] = '{8'b10101010, 8'h00, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 2};
    vecs[1] = '{8'b10101010, 8'h08, 1'b1, 1, 3, 1'b1, 1'b0, 1'b1, 3};
    vecs[2] = '{8'b11001100, 8'h81, 1'b0, 2, 0, 1'b1, 1'b0, 1'b1, 2};
    vecs[3] = '{8'h5A,       8'hFF, 1'b1, 8, 0, 1'b1, 1'b0, 1'b1, 3};
    vecs[4] = '{8'hF0,       8'h80, 1'b0, 1, 7, 1'b1, 1'b0, 1'b1, 3};
    vecs[5] = '{8'hFF,       8'h60, 1'b0, 2, 5, 1'b1, 1'b0, 1'b0, 0};
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_pass", int'(pass0), 0);
    chk("rst_smp", int'(smp0), 0);
    chk("rst_err", int'(err0), 0);
    chk("rst_vld", int'(vld0), 0);
    chk("rst_idx", int'(idx0), 0);
    chk("rst_busy2", int'(busy2), 0);
    rst_n = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) run(vecs[i], 0);
    run(vecs[1], 4);
    // Back-to-back: start held high through DONE.
    k1 = 0; k2 = 0;
    @(negedge clk);
    start = 1;
    for (int k = 1; k <= 40 && k2 == 0; k++) begin
      @(negedge clk);
      if (done0 && k1 == 0) begin
        k1 = k;
        chk("b2b_first_cycle", k, 9);
        chk("b2b_first_err", int'(err0), 8);
      end else if (k1 != 0 && k == k1 + 1) begin
        chk("b2b_restart_busy", int'(busy0), 1);
        chk("b2b_restart_done", int'(done0), 0);
        chk("b2b_cleared_err", int'(err0), 0);
        chk("b2b_cleared_smp", int'(smp0), 0);
        chk("b2b_cleared_vld", int'(vld0), 0);
        start = 0;
      end else if (done0 && k1 != 0) begin
        k2 = k;
        chk("b2b_second_cycle", k, 18);
        chk("b2b_second_pass", int'(pass0), 1);
        chk("b2b_second_smp", int'(smp0), 8);
      end
      drive(vecs[3], k);
    end
    if (k2 == 0) begin
      checks++; errors++;
      $display("FAIL b2b_timeout: first done %0d second done %0d", k1, k2);
    end
    start = 0;
    repeat (15) @(negedge clk);
    // Reset mid-CHECK with errors already counted.
    start = 1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 0;
      drive(vecs[3], k);
    end
    chk("pre_rst_busy", int'(busy0), 1);
    chk("pre_rst_err", int'(err0), 4);
    rst_n = 0;
    #1;
    chk("mid_rst_busy", int'(busy0), 0);
    chk("mid_rst_smp", int'(smp0), 0);
    chk("mid_rst_err", int'(err0), 0);
    chk("mid_rst_vld", int'(vld0), 0);
    chk("mid_rst_idx", int'(idx0), 0);
    chk("mid_rst_pass", int'(pass0), 0);
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    run(vecs[0], 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
